// File: rtl/stream_packer.sv
// Packs a narrow valid/ready beat stream into full-width words with lane-keep mask and
// last flag, and pushes them through a one-word output register into a push/full FIFO.
module stream_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH,
  localparam int LOG_RATIO = $clog2(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 in_vld_i,
  output logic                 in_rdy_o,
  input  logic [IN_WIDTH-1:0]  in_dat_i,
  input  logic                 in_last_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_push_o,
  output logic [OUT_WIDTH-1:0] fifo_dat_o,
  output logic [RATIO-1:0]     fifo_keep_o,
  output logic                 fifo_last_o
);

  logic [OUT_WIDTH-1:0] acc_r;
  logic [RATIO-1:0]     keep_r;
  logic [LOG_RATIO-1:0] idx_r;
  logic                 out_vld_r;
  logic [OUT_WIDTH-1:0] out_dat_r;
  logic [RATIO-1:0]     out_keep_r;
  logic                 out_last_r;

  logic [OUT_WIDTH-1:0] acc_wr_s;
  logic [RATIO-1:0]     keep_wr_s;
  logic                 in_rdy_s;
  logic                 accept_s;
  logic                 close_s;
  logic                 consume_s;

  // The input stalls only when the output register is occupied and cannot drain this cycle.
  assign in_rdy_s  = ~flush_i & (~out_vld_r | ~fifo_full_i);
  assign accept_s  = in_vld_i & in_rdy_s;
  assign close_s   = accept_s & ((idx_r == LOG_RATIO'(RATIO - 1)) | in_last_i);
  assign consume_s = out_vld_r & ~fifo_full_i;

  // Accumulator image with the current beat merged into lane idx_r.
  always_comb begin
    acc_wr_s  = acc_r;
    keep_wr_s = keep_r;
    acc_wr_s[int'(idx_r) * IN_WIDTH +: IN_WIDTH] = in_dat_i;
    keep_wr_s[idx_r] = 1'b1;
  end

  // Accumulator, keep mask and lane index; a close restarts the next word at lane 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_r  <= {OUT_WIDTH{1'b0}};
      keep_r <= {RATIO{1'b0}};
      idx_r  <= {LOG_RATIO{1'b0}};
    end else if (flush_i) begin
      acc_r  <= {OUT_WIDTH{1'b0}};
      keep_r <= {RATIO{1'b0}};
      idx_r  <= {LOG_RATIO{1'b0}};
    end else if (close_s) begin
      acc_r  <= {OUT_WIDTH{1'b0}};
      keep_r <= {RATIO{1'b0}};
      idx_r  <= {LOG_RATIO{1'b0}};
    end else if (accept_s) begin
      acc_r  <= acc_wr_s;
      keep_r <= keep_wr_s;
      idx_r  <= idx_r + LOG_RATIO'(1);
    end else begin
      acc_r  <= acc_r;
      keep_r <= keep_r;
      idx_r  <= idx_r;
    end
  end

  // Output word register; contents stay frozen while the FIFO is full.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_vld_r  <= 1'b0;
      out_dat_r  <= {OUT_WIDTH{1'b0}};
      out_keep_r <= {RATIO{1'b0}};
      out_last_r <= 1'b0;
    end else if (flush_i) begin
      out_vld_r  <= 1'b0;
      out_dat_r  <= {OUT_WIDTH{1'b0}};
      out_keep_r <= {RATIO{1'b0}};
      out_last_r <= 1'b0;
    end else if (close_s) begin
      out_vld_r  <= 1'b1;
      out_dat_r  <= acc_wr_s;
      out_keep_r <= keep_wr_s;
      out_last_r <= in_last_i;
    end else if (consume_s) begin
      out_vld_r  <= 1'b0;
    end else begin
      out_vld_r  <= out_vld_r;
    end
  end

  assign in_rdy_o    = in_rdy_s;
  assign fifo_push_o = out_vld_r;
  assign fifo_dat_o  = out_dat_r;
  assign fifo_keep_o = out_keep_r;
  assign fifo_last_o = out_last_r;

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: directed packets plus randomized traffic,
// checked against a byte-list reference model.
module tb_stream_packer;
  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 32;
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 in_vld_i = 1'b0;
  logic                 in_rdy_o;
  logic [IN_WIDTH-1:0]  in_dat_i = '0;
  logic                 in_last_i = 1'b0;
  logic                 fifo_full_i = 1'b0;
  logic                 fifo_push_o;
  logic [OUT_WIDTH-1:0] fifo_dat_o;
  logic [RATIO-1:0]     fifo_keep_o;
  logic                 fifo_last_o;

  stream_packer #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i), .in_last_i(in_last_i),
    .fifo_full_i(fifo_full_i), .fifo_push_o(fifo_push_o), .fifo_dat_o(fifo_dat_o),
    .fifo_keep_o(fifo_keep_o), .fifo_last_o(fifo_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [OUT_WIDTH-1:0] dat; logic [RATIO-1:0] keep; logic last; } word_t;

  word_t      exp_q[$];
  logic [7:0] beats[$];
  bit         occ = 1'b0;   // model: output register holds a word
  bit         m_acc = 1'b0; // model: beat accepted at the latest edge
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted bytes, emit a word on RATIO bytes or last.
  always @(posedge clk_i) begin
    bit rdy, cons;
    word_t w;
    m_acc = 1'b0;
    if (!rst_n_i || flush_i) begin
      occ = 1'b0;
      beats.delete();
      exp_q.delete();
    end else begin
      rdy  = !occ || !fifo_full_i;
      cons = occ && !fifo_full_i;
      if (in_vld_i && rdy) begin
        m_acc = 1'b1;
        beats.push_back(in_dat_i);
        if (beats.size() == RATIO || in_last_i) begin
          w.dat = '0;
          for (int i = 0; i < beats.size(); i++) w.dat = w.dat | (OUT_WIDTH'(beats[i]) << (8 * i));
          w.keep = RATIO'((1 << beats.size()) - 1);
          w.last = in_last_i;
          exp_q.push_back(w);
          beats.delete();
          occ = 1'b1;
        end else if (cons) occ = 1'b0;
      end else if (cons) occ = 1'b0;
    end
  end

  // Monitor: compares the DUT output against the scoreboard head mid-cycle.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      chk("in_rdy", 64'(in_rdy_o), 64'(!flush_i && (!occ || !fifo_full_i)));
      chk("push", 64'(fifo_push_o), 64'(occ));
      if (fifo_push_o && exp_q.size() > 0) begin
        chk("dat", 64'(fifo_dat_o), 64'(exp_q[0].dat));
        chk("keep", 64'(fifo_keep_o), 64'(exp_q[0].keep));
        chk("last", 64'(fifo_last_o), 64'(exp_q[0].last));
        if (!fifo_full_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    in_vld_i = 1'b1; in_dat_i = d; in_last_i = l;
    do begin cyc(); n++; end while (!m_acc && n < 200);
    if (!m_acc) begin
      errors++; checks++;
      $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", d);
    end
    in_vld_i = 1'b0; in_last_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    chk("rst_push", 64'(fifo_push_o), 64'd0);
    chk("rst_dat", 64'(fifo_dat_o), 64'd0);
    chk("rst_keep", 64'(fifo_keep_o), 64'd0);
    chk("rst_last", 64'(fifo_last_o), 64'd0);
    rst_n_i = 1'b1;
    cyc();
    chk("rdy_after_rst", 64'(in_rdy_o), 64'd1);

    // Two full words back to back, then partial packets.
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), i == 8);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    send(8'h5A, 1'b1);
    repeat (3) cyc();

    // Back-pressure: first word held while full, later beats stall.
    fifo_full_i = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    in_vld_i = 1'b1; in_dat_i = 8'h05;
    repeat (10) cyc();
    fifo_full_i = 1'b0;
    for (int i = 5; i <= 12; i++) send(8'(i), 1'b0);
    repeat (3) cyc();

    // Flush drops a partial word.
    send(8'hE1, 1'b0); send(8'hE2, 1'b0);
    flush_i = 1'b1; cyc(); flush_i = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    repeat (3) cyc();

    // Asynchronous reset while a word is presented, with a partial word behind it.
    fifo_full_i = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(8'h90 + i), 1'b0);
    in_vld_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_push", 64'(fifo_push_o), 64'd0);
    chk("arst_dat", 64'(fifo_dat_o), 64'd0);
    chk("arst_keep", 64'(fifo_keep_o), 64'd0);
    chk("arst_last", 64'(fifo_last_o), 64'd0);
    cyc(); cyc();
    fifo_full_i = 1'b0;
    rst_n_i = 1'b1;
    cyc();
    chk("rdy_after_arst", 64'(in_rdy_o), 64'd1);
    send(8'h77, 1'b1);
    repeat (3) cyc();

    // Randomized traffic with back-pressure and occasional flush.
    for (int c = 0; c < 4000; c++) begin
      fifo_full_i = ($urandom % 10) < 3;
      flush_i     = ($urandom % 80) == 0;
      in_vld_i    = ($urandom % 4) != 0;
      in_dat_i    = 8'($urandom);
      in_last_i   = ($urandom % 6) == 0;
      cyc();
    end
    flush_i = 1'b0; fifo_full_i = 1'b0; in_vld_i = 1'b0; in_last_i = 1'b0;
    repeat (4) cyc();
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_packer.md
# stream_packer

Upstream width-converting stage that packs a narrow valid/ready byte stream into full-width words and pushes them into the synchronous FIFO that follows it (push/full interface). Partial words are closed by an end-of-packet marker and carry a lane-keep mask and last flag alongside the data. A one-word registered output stage decouples FIFO back-pressure from the input, so the input sustains one beat per cycle while the FIFO is not full.

## Interface
- IN_WIDTH, 8, input beat width in bits
- OUT_WIDTH, 32, output word width; OUT_WIDTH/IN_WIDTH = RATIO must be a power of two ≥ 2
- RATIO, OUT_WIDTH/IN_WIDTH, lanes per word (derived; not overridden)
- LOG_RATIO, $clog2(RATIO), lane index width (derived)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear; drops partial and buffered data
- in_vld_i  in  1  input beat valid
- in_rdy_o  out  1  input beat ready
- in_dat_i  in  IN_WIDTH  input beat data
- in_last_i  in  1  beat is the final beat of a packet
- fifo_full_i  in  1  downstream FIFO full
- fifo_push_o  out  1  output word valid / push request
- fifo_dat_o  out  OUT_WIDTH  packed word
- fifo_keep_o  out  RATIO  lane valid mask, bit i ↔ bits [i*IN_WIDTH +: IN_WIDTH]
- fifo_last_o  out  1  word closes a packet

## Operation
- Input handshake: beat accepted when in_vld_i & in_rdy_o. Output handshake: word consumed when fifo_push_o & ~fifo_full_i.
- in_rdy_o = ~flush_i & (~out_vld_q | ~fifo_full_i). No combinational dependence on in_vld_i, in_dat_i or in_last_i.
- Accumulator: data register acc_q (OUT_WIDTH), keep register keep_q (RATIO), lane index idx_q (LOG_RATIO). Little-endian lanes: first beat of a word lands in lane 0.
- Accepted beat writes in_dat_i into lane idx_q of acc_q and sets keep_q[idx_q].
- Word closes when the accepted beat has idx_q == RATIO-1 or in_last_i = 1. On close: {acc with current beat, keep with current bit, in_last_i} moves into the output register; out_vld_q set; acc_q, keep_q, idx_q clear to 0 in the same cycle. Otherwise idx_q increments.
- Lanes not written in a partial word are 0 in fifo_dat_o; their keep bits are 0.
- Output register: fifo_push_o = out_vld_q. Data, keep and last are held stable while fifo_push_o = 1 and fifo_full_i = 1. Consumption without a new close clears out_vld_q; consumption plus close in the same cycle reloads the register and keeps out_vld_q = 1.
- idx_q wraps RATIO-1 → 0 only via close; never exceeds RATIO-1.
- in_last_i on lane 0 yields a single-lane word, keep = 0…01.
- flush_i (highest priority): next cycle acc_q, keep_q, idx_q, out_vld_q, output data/keep/last = 0; no beat accepted and no word pushed in the flush cycle (fifo_push_o may be 1 in the flush cycle; the FIFO is flushed by the same signal).

## Timing
- Reset (asynchronous assert): fifo_push_o = 0, fifo_dat_o = 0, fifo_keep_o = 0, fifo_last_o = 0, internal state 0; in_rdy_o = 1 once rst_n_i is high and flush_i is low.
- Latency: beat that closes a word accepted in cycle N → fifo_push_o = 1 in cycle N+1.
- Throughput: one beat per cycle while fifo_full_i = 0; one word per RATIO cycles at full rate.
- Back-pressure: fifo_full_i = 1 with out_vld_q = 1 drops in_rdy_o in the same cycle; accumulator contents and idx_q are preserved.
- Reset deassertion mid-packet: no partial word is emitted; all state restarts from lane 0.

## Test plan
- Reset, then 8 back-to-back beats 0x11..0x88, last on 0x88, FIFO never full -> pushes 0x44332211 keep 0xF last 0 at cycle 5, 0x88776655 keep 0xF last 1 at cycle 9; in_rdy_o high throughout.
- 3 beats 0xAA,0xBB,0xCC with last on 0xCC -> single push 0x00CCBBAA, keep 0x7, last 1; next packet starts at lane 0.
- Single beat 0x5A with last -> push 0x0000005A, keep 0x1, last 1.
- Hold fifo_full_i = 1 while streaming 12 beats -> first word held stable on fifo_push_o, in_rdy_o drops with out_vld_q set; release full -> words 1..3 emitted in order, no loss or duplication.
- 2 beats accepted then flush_i for one cycle, then 4 beats 0x01..0x04 -> no word from the pre-flush beats; push 0x04030201 keep 0xF.
- Assert rst_n_i low asynchronously while fifo_push_o = 1 -> all outputs 0 immediately without a clock edge; after release, in_rdy_o = 1 and next word starts at lane 0.
